// File: rtl/octal_psram_pkg.sv
// octal_psram_pkg
//   Shared definitions for the octal PSRAM responder: command codes, the
//   device FSM state set, address framing and the default read latency.
package octal_psram_pkg;

  localparam logic [7:0] CMD_RD_SINGLE = 8'h00;
  localparam logic [7:0] CMD_RD_BURST  = 8'h20;
  localparam logic [7:0] CMD_WR_SINGLE = 8'h80;
  localparam logic [7:0] CMD_WR_BURST  = 8'hA0;

  localparam int ADDR_BYTES  = 4;
  localparam int DEF_LATENCY = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RLAT,
    ST_RDATA,
    ST_IGNORE
  } state_e;

  function automatic logic cmd_supported(input logic [7:0] c);
    return (c == CMD_RD_SINGLE) || (c == CMD_RD_BURST) ||
           (c == CMD_WR_SINGLE) || (c == CMD_WR_BURST);
  endfunction

  // bit 7 selects write, bit 5 selects burst for every supported code
  function automatic logic cmd_is_write(input logic [7:0] c);
    return c[7];
  endfunction

  function automatic logic cmd_is_burst(input logic [7:0] c);
    return c[5];
  endfunction

endpackage

// File: rtl/psram_resp_ram.sv
// psram_resp_ram
//   DEPTH x 16 backing store for the PSRAM responder.
//   Ports:
//     i_clk    : system clock
//     i_we     : write strobe
//     i_be     : byte enables, [1] = high byte, [0] = low byte
//     i_waddr  : write word address
//     i_wdata  : write word
//     i_raddr  : read word address
//     o_rdata  : registered read word (one cycle after i_raddr)
module psram_resp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [1:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      if (i_be[1]) r_mem[i_waddr][15:8] <= i_wdata[15:8];
      if (i_be[0]) r_mem[i_waddr][7:0]  <= i_wdata[7:0];
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/octal_psram_responder.sv
// octal_psram_responder
//   Device-side model of the octal PSRAM bus. All bus pins are oversampled
//   on iClk, commands/addresses are decoded, writes land in an internal RAM
//   and reads are returned after a fixed number of PSRAM_CLK rising edges.
//   Ports:
//     iClk         : system clock (>= 4x PSRAM_CLK)
//     iRst_N       : async active-low reset (clears everything incl. oCmdErr)
//     iPSRAM_RST   : device reset, active-low; FSM only, RAM and counters kept
//     iPSRAM_CE    : chip enable, active-low
//     iPSRAM_CLK   : bus clock from the host
//     ioPSRAM_DATA : command/address/data byte lane
//     ioPSRAM_DQS  : write mask from host / read strobe from responder
//     oBusy        : transaction in progress
//     oCmdErr      : sticky unsupported-command flag
//     oWrWordCnt   : saturating count of committed write words
module octal_psram_responder
  import octal_psram_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        iClk,
  input  logic        iRst_N,
  input  logic        iPSRAM_RST,
  input  logic        iPSRAM_CE,
  input  logic        iPSRAM_CLK,
  inout  wire  [7:0]  ioPSRAM_DATA,
  inout  wire         ioPSRAM_DQS,
  output logic        oBusy,
  output logic        oCmdErr,
  output logic [15:0] oWrWordCnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AIW = $clog2(ADDR_BYTES);
  localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);

  // synchronizer bundle: {dev_rst_n, ce_n, clk, dqs, data[7:0]}
  localparam int SW = 12;
  localparam logic [SW-1:0] SYNC_RST = {1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

  logic [SW-1:0] w_pins;
  logic [SW-1:0] r_s1, r_s2;
  logic          r_clk_s3, r_ce_s3;

  assign w_pins = {iPSRAM_RST, iPSRAM_CE, iPSRAM_CLK, ioPSRAM_DQS, ioPSRAM_DATA};

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_s1     <= SYNC_RST;
      r_s2     <= SYNC_RST;
      r_clk_s3 <= 1'b0;
      r_ce_s3  <= 1'b1;
    end else begin
      r_s1     <= w_pins;
      r_s2     <= r_s1;
      r_clk_s3 <= r_s2[9];
      r_ce_s3  <= r_s2[10];
    end
  end

  logic       w_dev_rst_n, w_ce_n, w_ce_fall, w_clk_rise, w_clk_fall, w_mask;
  logic [7:0] w_data;

  assign w_dev_rst_n = r_s2[11];
  assign w_ce_n      = r_s2[10];
  assign w_ce_fall   = ~r_s2[10] & r_ce_s3;
  assign w_clk_rise  =  r_s2[9] & ~r_clk_s3;
  assign w_clk_fall  = ~r_s2[9] &  r_clk_s3;
  assign w_mask      = r_s2[8];
  assign w_data      = r_s2[7:0];

  // FSM and datapath registers
  state_e          r_state;
  logic            r_busy, r_cmd_err;
  logic            r_is_wr, r_is_burst;
  logic [AIW-1:0]  r_addr_idx;
  logic [AW-1:0]   r_waddr, r_raddr;
  logic            r_byte_sel;            // 0 = high byte next, 1 = low byte next
  logic [7:0]      r_hi_byte;
  logic            r_hi_mask;
  logic [7:0]      r_lat_cnt;
  logic [7:0]      r_lo_byte;
  logic [7:0]      r_data_out;
  logic            r_dqs_out;
  logic            r_data_oe, r_dqs_oe;
  logic            r_we;
  logic [AW-1:0]   r_wr_addr;
  logic [15:0]     r_wr_data;
  logic [1:0]      r_wr_be;
  logic [15:0]     r_wr_cnt;

  logic [AW-1:0]   w_addr_next;
  logic [15:0]     w_ram_q;

  // Only the word-address bits of the 32-bit bus address are kept; shifting
  // each byte in and truncating leaves addr[AW-1:0] after the last byte.
  assign w_addr_next = AW'({r_waddr, w_data});

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_is_wr    <= 1'b0;
      r_is_burst <= 1'b0;
      r_addr_idx <= '0;
      r_waddr    <= '0;
      r_raddr    <= '0;
      r_byte_sel <= 1'b0;
      r_hi_byte  <= '0;
      r_hi_mask  <= 1'b0;
      r_lat_cnt  <= '0;
      r_lo_byte  <= '0;
      r_data_out <= '0;
      r_dqs_out  <= 1'b0;
      r_data_oe  <= 1'b0;
      r_dqs_oe   <= 1'b0;
      r_we       <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_be    <= '0;
      r_wr_cnt   <= '0;
    end else begin
      r_we <= 1'b0;
      // counter moves on the same edge the RAM takes the write
      if (r_we && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;

      // CE high (or device reset) beats any coincident clock edge
      if (!w_dev_rst_n || w_ce_n) begin
        r_state    <= ST_IDLE;
        r_busy     <= 1'b0;
        r_data_oe  <= 1'b0;
        r_dqs_oe   <= 1'b0;
        r_byte_sel <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_ce_fall) begin
              r_state <= ST_CMD;
              r_busy  <= 1'b1;
            end
          end

          ST_CMD: begin
            if (w_clk_rise) begin
              r_is_wr    <= cmd_is_write(w_data);
              r_is_burst <= cmd_is_burst(w_data);
              r_addr_idx <= '0;
              if (cmd_supported(w_data)) begin
                r_state <= ST_ADDR;
              end else begin
                r_cmd_err <= 1'b1;
                r_state   <= ST_IGNORE;
              end
            end
          end

          ST_ADDR: begin
            if (w_clk_rise) begin
              r_waddr    <= w_addr_next;
              r_addr_idx <= r_addr_idx + AIW'(1);
              if (r_addr_idx == AIW'(ADDR_BYTES - 1)) begin
                r_raddr    <= w_addr_next;
                r_byte_sel <= 1'b0;
                r_lat_cnt  <= '0;
                r_state    <= r_is_wr ? ST_WDATA : ST_RLAT;
              end
            end
          end

          ST_WDATA: begin
            if (w_clk_rise) begin
              if (!r_byte_sel) begin
                r_hi_byte  <= w_data;
                r_hi_mask  <= w_mask;
                r_byte_sel <= 1'b1;
              end else begin
                // commit; a masked byte simply has its enable dropped
                r_we       <= 1'b1;
                r_wr_addr  <= r_waddr;
                r_wr_data  <= {r_hi_byte, w_data};
                r_wr_be    <= {~r_hi_mask, ~w_mask};
                r_waddr    <= r_waddr + AW'(1);
                r_byte_sel <= 1'b0;
                if (!r_is_burst) r_state <= ST_IGNORE;
              end
            end
          end

          ST_RLAT: begin
            if (w_clk_rise) begin
              if (r_lat_cnt == LAT_LAST) begin
                r_state    <= ST_RDATA;
                r_data_oe  <= 1'b1;
                r_dqs_oe   <= 1'b1;
                r_dqs_out  <= 1'b0;
                r_data_out <= '0;
                r_byte_sel <= 1'b0;
              end else begin
                r_lat_cnt <= r_lat_cnt + 8'd1;
              end
            end
          end

          ST_RDATA: begin
            if (w_clk_fall) begin
              r_dqs_out <= ~r_dqs_out;
              if (!r_byte_sel) begin
                // latch the low byte and advance the read address now so the
                // next word is already in the RAM output register
                r_data_out <= w_ram_q[15:8];
                r_lo_byte  <= w_ram_q[7:0];
                r_raddr    <= r_raddr + AW'(1);
                r_byte_sel <= 1'b1;
              end else begin
                r_data_out <= r_lo_byte;
                r_byte_sel <= 1'b0;
                if (!r_is_burst) r_state <= ST_IGNORE;
              end
            end
          end

          ST_IGNORE: ;

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  psram_resp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (iClk),
    .i_we    (r_we),
    .i_be    (r_wr_be),
    .i_waddr (r_wr_addr),
    .i_wdata (r_wr_data),
    .i_raddr (r_raddr),
    .o_rdata (w_ram_q)
  );

  assign ioPSRAM_DATA = r_data_oe ? r_data_out : 8'hzz;
  assign ioPSRAM_DQS  = r_dqs_oe  ? r_dqs_out  : 1'bz;

  assign oBusy      = r_busy;
  assign oCmdErr    = r_cmd_err;
  assign oWrWordCnt = r_wr_cnt;

endmodule

// File: doc/octal_psram_responder.md
# octal_psram_responder

Synthesizable device-side model of the octal PSRAM bus driven by the team's PSRAM controller. It samples CE/CLK/DATA/DQS as the memory would, decodes command and address, stores write words in an internal RAM, and returns read words with a fixed latency. It is used for on-FPGA loopback tests of the controller and as the bench target for the controller's write/read frame paths.

## Interface
- DEPTH, 1024: words of backing store (16-bit words); power of two.
- LATENCY, 5: PSRAM_CLK rising edges between the last address byte and the first read data byte.
- iClk  in  1: system clock; must be at least 4x the PSRAM_CLK rate.
- iRst_N  in  1: asynchronous, active-low reset.
- iPSRAM_RST  in  1: device reset, active-low; resets the FSM synchronously and leaves RAM contents intact.
- iPSRAM_CE  in  1: chip enable, active-low.
- iPSRAM_CLK  in  1: bus clock from the host; oversampled.
- ioPSRAM_DATA  inout  8: command, address and data bytes.
- ioPSRAM_DQS  inout  8→1: 1 bit. Write mask from the host during writes (1 = byte masked); strobe driven by the responder during reads.
- oBusy  out  1: high while CE is low and a transaction is decoded.
- oCmdErr  out  1: sticky; set on an unsupported command byte. Cleared by iRst_N.
- oWrWordCnt  out  16: words committed since reset; saturates at 0xFFFF.

## Operation
- Inputs pass through 2-flop synchronizers. A PSRAM_CLK rising or falling event is detected from the 2nd/3rd synchronizer stages.
- Commands (shared package):
  - 0x00: single read.
  - 0x20: burst read.
  - 0x80: single write.
  - 0xA0: burst write.
  - Any other value: sets oCmdErr and goes to IGNORE.
- States:
  - IDLE: CE falling → CMD.
  - CMD: first rising event latches the command → ADDR.
  - ADDR: 4 bytes, MSB first, on rising events. A 32-bit address is formed; word address = addr[log2(DEPTH)-1:0]. After the 4th byte → WDATA (write command) or RLAT (read command).
  - WDATA: each rising event takes one byte. Even bytes are the high byte, odd bytes the low byte. The word commits on the odd byte. A DQS-masked byte keeps the old RAM byte. Single write: after one word → IGNORE. Burst write: the address increments and wraps at DEPTH-1 → 0.
  - RLAT: counts LATENCY rising events → RDATA.
  - RDATA: on each falling event, drive the next byte (high byte first) and toggle DQS. The word address increments after the low byte, with the same wrap rule. Single read: one word → IGNORE. Burst read: continues until CE goes high.
  - IGNORE: waits for CE high.
- CE high in any state → IDLE within 3 iClk. A partial write word is discarded, and the output drivers release in the same cycle IDLE is entered.
- Simultaneous CE rise and a CLK edge: CE wins, and the edge is ignored.
- iPSRAM_RST low: FSM → IDLE, drivers released, counters kept.

## Timing
- Reset values:
  - ioPSRAM_DATA and ioPSRAM_DQS: high-Z (output enables 0).
  - oBusy: 0.
  - oCmdErr: 0.
  - oWrWordCnt: 0.
  - FSM: IDLE.
- Pin-to-decision latency is 3 iClk (2 sync + 1 edge register).
- RAM write occurs 1 iClk after the commit decision. RAM read is registered (1 iClk). The next word is prefetched during the high-byte phase so the low byte is never late.
- Read data and DQS change on the iClk after a detected falling event, giving the host half a PSRAM_CLK of setup before its rising edge.
- oWrWordCnt increments in the same cycle as the RAM write.

## Structure
- Package octal_psram_pkg holds:
  - Command codes.
  - The FSM state enum.
  - The address byte count (4).
  - The default LATENCY.
- Sub-module psram_resp_ram: DEPTH×16 RAM with one write port and one registered read port, plus per-byte write enables for the DQS mask.
- All other logic stays in the top module: synchronizers, edge detect, FSM, counters and tri-state control.

## Test plan
- Single write: 0x80, address 0x00000010, data 0xBEEF → RAM[16] = 0xBEEF, oWrWordCnt = 1, drivers never enabled.
- Burst read: 0x20 at address 0x10 after writes 0xBEEF/0x1234 to 0x10/0x11 → after 5 CLK rises, bytes BE EF 12 34 appear on DATA, DQS toggles 4 times.
- Wrap: burst write 3 words at address DEPTH-1 → words land at DEPTH-1, 0, 1.
- DQS mask: write 0xAABB over 0xBEEF with the high byte masked → RAM = 0xBEBB.
- Abort: raise CE after 1 data byte of a burst write → no RAM change, oWrWordCnt unchanged, state IDLE within 3 iClk. The next transaction decodes normally.
- Bad command 0x55 → oCmdErr = 1, no bus drive until CE high. iRst_N low mid-read → DATA/DQS high-Z immediately, oCmdErr = 0.
